// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: steps the PWM duty toward an accepted target, one step per (dwell+1) PWM periods.
// Define PWM_RAMP_ABORT_EN to add an abort input that stops a ramp at its current duty.
module pwm_ramp_ctrl #(
    parameter int DUTY_W  = 7,
    parameter int CNT_W   = 3,
    parameter int STEP    = 1,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
`ifdef PWM_RAMP_ABORT_EN
    input  logic               abort,
`endif
    input  logic               tgt_valid,
    output logic               tgt_ready,
    input  logic [DUTY_W-1:0]  tgt_duty,
    input  logic [DWELL_W-1:0] dwell,
    output logic [DUTY_W-1:0]  duty,
    output logic               period_start,
    output logic               busy,
    output logic               done
);
    typedef enum logic {IDLE, RAMP} state_t;
    localparam logic [DUTY_W:0] STEP_W = (DUTY_W + 1)'(STEP);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DUTY_W-1:0]  target;
    logic [DUTY_W-1:0]  next_duty;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DUTY_W:0]    gap;
    logic               period_end;
    logic               up;
    logic               stop;
`ifdef PWM_RAMP_ABORT_EN
    assign stop = abort;
`else
    assign stop = 1'b0;
`endif
    assign period_end = enable && cnt == '1;
    assign tgt_ready  = state == IDLE;
    assign busy       = state == RAMP;
    assign up         = target > duty;
    assign gap        = up ? {1'b0, target} - {1'b0, duty} : {1'b0, duty} - {1'b0, target};
    // Clamp to the target when within one step so the duty never overshoots or wraps.
    assign next_duty  = gap <= STEP_W ? target
                      : up ? duty + STEP_W[DUTY_W-1:0] : duty - STEP_W[DUTY_W-1:0];
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            duty         <= '0;
            target       <= '0;
            dwell_q      <= '0;
            dwell_cnt    <= '0;
            period_start <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (enable) cnt <= cnt + 1'b1;
            period_start <= period_end;
            done         <= 1'b0;
            if (state == IDLE) begin
                if (tgt_valid) begin
                    target    <= tgt_duty;
                    dwell_q   <= dwell;
                    dwell_cnt <= dwell;
                    if (tgt_duty == duty) done <= 1'b1;
                    else state <= RAMP;
                end
            end else if (stop) begin
                state     <= IDLE;
                dwell_cnt <= '0;
            end else if (period_end) begin
                if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
                else begin
                    duty      <= next_duty;
                    dwell_cnt <= dwell_q;
                    if (next_duty == target) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: drives two controllers (STEP=1 and STEP=2) with shared stimulus
// and compares every output each cycle against a period-level behavioural model.
module tb_pwm_ramp_ctrl;
    localparam int DW = 7;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          tgt_valid = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] tgt_duty = '0;
    logic [7:0]    dwell = '0;
    logic [1:0]    ready, busy, done, ps;
    logic [DW-1:0] duty [2];
    int            total = 0, bad = 0;
    int            m_cnt = 0, m_duty [2], m_tgt [2], m_dw [2], m_left [2];
    bit            m_ramp [2], m_done [2], m_ps = 0;
    always #5 clk = ~clk;
    pwm_ramp_ctrl #(.STEP(1)) u1 (
        .clk(clk), .rst(rst), .enable(enable),
`ifdef PWM_RAMP_ABORT_EN
        .abort(abort),
`endif
        .tgt_valid(tgt_valid), .tgt_ready(ready[0]), .tgt_duty(tgt_duty), .dwell(dwell),
        .duty(duty[0]), .period_start(ps[0]), .busy(busy[0]), .done(done[0])
    );
    pwm_ramp_ctrl #(.STEP(2)) u2 (
        .clk(clk), .rst(rst), .enable(enable),
`ifdef PWM_RAMP_ABORT_EN
        .abort(abort),
`endif
        .tgt_valid(tgt_valid), .tgt_ready(ready[1]), .tgt_duty(tgt_duty), .dwell(dwell),
        .duty(duty[1]), .period_start(ps[1]), .busy(busy[1]), .done(done[1])
    );
    // Model: period phase 0..7, per controller the duty/target and periods left before the next step.
    task automatic model();
        bit pe;
        bit ab;
        int s;
        pe = enable && m_cnt == 7;
        ab = 1'b0;
`ifdef PWM_RAMP_ABORT_EN
        ab = abort;
`endif
        if (rst) begin
            m_cnt = 0;
            m_ps = 0;
            for (int k = 0; k < 2; k++) begin
                m_duty[k] = 0; m_ramp[k] = 0; m_done[k] = 0; m_left[k] = 0;
            end
        end else begin
            m_ps = pe;
            for (int k = 0; k < 2; k++) begin
                s = k + 1;
                m_done[k] = 0;
                if (!m_ramp[k]) begin
                    if (tgt_valid) begin
                        m_tgt[k] = tgt_duty; m_dw[k] = dwell; m_left[k] = dwell;
                        if (m_tgt[k] == m_duty[k]) m_done[k] = 1;
                        else m_ramp[k] = 1;
                    end
                end else if (ab) begin
                    m_ramp[k] = 0; m_left[k] = 0;
                end else if (pe) begin
                    if (m_left[k] > 0) m_left[k]--;
                    else begin
                        if (m_tgt[k] > m_duty[k]) m_duty[k] = (m_duty[k] + s < m_tgt[k]) ? m_duty[k] + s : m_tgt[k];
                        else m_duty[k] = (m_duty[k] - s > m_tgt[k]) ? m_duty[k] - s : m_tgt[k];
                        m_left[k] = m_dw[k];
                        if (m_duty[k] == m_tgt[k]) begin
                            m_done[k] = 1; m_ramp[k] = 0;
                        end
                    end
                end
            end
            m_cnt = (m_cnt + int'(enable)) % 8;
        end
    endtask
    task automatic chk(string tag, int k, logic [31:0] got, int exp);
        total++;
        assert (got === 32'(exp)) else begin
            bad++;
            $error("FAIL %s[%0d] got=%0d exp=%0d t=%0t", tag, k, got, exp, $time);
        end
    endtask
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model();
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("duty", k, 32'(duty[k]), m_duty[k]);
                chk("tgt_ready", k, 32'(ready[k]), int'(!m_ramp[k]));
                chk("busy", k, 32'(busy[k]), int'(m_ramp[k]));
                chk("done", k, 32'(done[k]), int'(m_done[k]));
                chk("period_start", k, 32'(ps[k]), int'(m_ps));
            end
        end
    endtask
    task automatic wait_idle(int limit);
        int n = 0;
        while ((m_ramp[0] || m_ramp[1]) && n < limit) begin
            tick();
            n++;
        end
        total++;
        assert (!(m_ramp[0] || m_ramp[1])) else begin
            bad++;
            $error("FAIL wait_idle got=busy exp=idle within %0d cycles", limit);
        end
    endtask
    task automatic wait_duty(int d, int limit);
        int n = 0;
        while (m_duty[0] != d && n < limit) begin
            tick();
            n++;
        end
        total++;
        assert (m_duty[0] == d) else begin
            bad++;
            $error("FAIL wait_duty got=%0d exp=%0d", m_duty[0], d);
        end
    endtask
    task automatic offer(int td, int dw);
        tgt_valid = 1'b1; tgt_duty = DW'(td); dwell = 8'(dw);
        tick();
        tgt_valid = 1'b0;
    endtask
    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(20);
        offer(3, 0);
        wait_idle(200);
        offer(5, 0);
        wait_idle(200);
        offer(0, 0);
        wait_idle(200);
        offer(2, 2);
        tick(30);
        enable = 1'b0;
        tick(20);
        enable = 1'b1;
        wait_idle(300);
        offer(6, 0);
        tick(3);
        tgt_valid = 1'b1; tgt_duty = 7'd9;
        tick(5);
        tgt_valid = 1'b0;
        wait_idle(200);
        offer(6, 0);
        tick(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        offer(6, 0);
        wait_duty(2, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick(3);
        offer(6, 0);
        wait_duty(4, 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick(12);
        wait_idle(200);
        repeat (800) begin
            rst       = $urandom_range(0, 99) == 0;
            enable    = $urandom_range(0, 9) != 0;
            tgt_valid = $urandom_range(0, 3) == 0;
            tgt_duty  = DW'($urandom_range(0, 15));
            dwell     = 8'($urandom_range(0, 2));
            abort     = $urandom_range(0, 29) == 0;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
